// File: rtl/axis_width_pkg.sv
// Shared types and helpers for the AXI-Stream down-sizing width converter.
//
// Contents:
//   state_e     - converter occupancy state (StEmpty / StBusy).
//   MaxKeepBits - widest tkeep vector last_slice() can scan.
//   last_slice  - index of the highest output slice that holds any enabled byte.
package axis_width_pkg;

  // Upper bound on input beat width, in bytes, for the trimming helper.
  localparam int unsigned MaxKeepBits = 128;

  typedef enum logic {
    StEmpty,
    StBusy
  } state_e;

  // Returns the index of the highest slice (slice_bytes wide, r slices in total)
  // with at least one set keep bit. An all-zero keep yields slice 0, so a
  // packet end is never dropped.
  function automatic int unsigned last_slice(input logic [MaxKeepBits-1:0] keep,
                                             input int unsigned            r,
                                             input int unsigned            slice_bytes);
    int unsigned last;
    last = 0;
    for (int unsigned b = 0; b < MaxKeepBits; b++) begin
      if ((b < r * slice_bytes) && keep[b]) begin
        last = b / slice_bytes;
      end
    end
    return last;
  endfunction

endpackage

// File: rtl/axis_width_down.sv
// AXI-Stream down-sizing width converter.
//
// Each accepted AXIS_I_BYTES-wide input beat is held in a single register and
// replayed as R = AXIS_I_BYTES/AXIS_O_BYTES output beats, least-significant
// slice first. tuser is repeated on every slice; tlast appears only on the final
// slice of a beat that carried tlast. When the final slice is taken and a new
// input beat is waiting, the new beat is loaded in the same cycle, so the
// output runs at one beat per cycle with no bubble.
//
// Build option:
//   AXIS_WIDTH_DOWN_TRIM_EN - on a tlast beat, stop after the highest slice that
//   holds any set tkeep bit (slice 0 if tkeep is all zero). Without it, every
//   input beat always yields exactly R output beats.
//
// Ports:
//   clk, sresetn     - clock; synchronous active-low reset.
//   axis_i_*         - wide input stream (tready, tvalid, tlast, tkeep, tdata, tuser).
//   axis_o_*         - narrow output stream (tready, tvalid, tlast, tkeep, tdata, tuser).
module axis_width_down
  import axis_width_pkg::*;
#(
  parameter int unsigned AXIS_I_BYTES   = 4,
  parameter int unsigned AXIS_O_BYTES   = 1,
  parameter int unsigned AXIS_USER_BITS = 1
) (
  input  logic                        clk,
  input  logic                        sresetn,

  output logic                        axis_i_tready,
  input  logic                        axis_i_tvalid,
  input  logic                        axis_i_tlast,
  input  logic [AXIS_I_BYTES-1:0]     axis_i_tkeep,
  input  logic [8*AXIS_I_BYTES-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]   axis_i_tuser,

  input  logic                        axis_o_tready,
  output logic                        axis_o_tvalid,
  output logic                        axis_o_tlast,
  output logic [AXIS_O_BYTES-1:0]     axis_o_tkeep,
  output logic [8*AXIS_O_BYTES-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]   axis_o_tuser
);

  localparam int unsigned R       = AXIS_I_BYTES / AXIS_O_BYTES;
  localparam int unsigned IdxW    = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned IDataW  = 8 * AXIS_I_BYTES;
  localparam int unsigned ODataW  = 8 * AXIS_O_BYTES;
  localparam logic [IdxW-1:0] FinFull = IdxW'(R - 1);

  // Elaboration-time parameter checks.
  if ((AXIS_I_BYTES % AXIS_O_BYTES) != 0) begin : g_err_multiple
    $error("axis_width_down: AXIS_I_BYTES must be a multiple of AXIS_O_BYTES");
  end
  if (R < 1) begin : g_err_ratio
    $error("axis_width_down: AXIS_I_BYTES/AXIS_O_BYTES must be at least 1");
  end
`ifdef AXIS_WIDTH_DOWN_TRIM_EN
  if (AXIS_I_BYTES > MaxKeepBits) begin : g_err_keep_width
    $error("axis_width_down: AXIS_I_BYTES exceeds the trimming helper width");
  end
`endif

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_e                       state_q, state_d;
  logic   [IdxW-1:0]            idx_q, idx_d;
  logic   [IdxW-1:0]            fin_q, fin_d;
  logic   [IDataW-1:0]          data_q, data_d;
  logic   [AXIS_I_BYTES-1:0]    keep_q, keep_d;
  logic   [AXIS_USER_BITS-1:0]  user_q, user_d;
  logic                         last_q, last_d;

  logic slice_last;
  logic in_hs;
  logic out_hs;

  assign slice_last = (idx_q == fin_q);
  assign in_hs      = axis_i_tvalid && axis_i_tready;
  assign out_hs     = axis_o_tvalid && axis_o_tready;

`ifdef AXIS_WIDTH_DOWN_TRIM_EN
  logic [MaxKeepBits-1:0] keep_ext;

  always_comb begin
    keep_ext                    = '0;
    keep_ext[AXIS_I_BYTES-1:0]  = axis_i_tkeep;
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (in_hs) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Final slice leaving with nothing waiting upstream drains the register;
        // if a beat is waiting it is loaded in the same cycle and we stay busy.
        if (out_hs && slice_last && !axis_i_tvalid) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    axis_o_tvalid = (state_q == StBusy);
    axis_i_tready = (state_q == StEmpty) || (axis_o_tready && slice_last);
    axis_o_tlast  = last_q && slice_last;
    axis_o_tuser  = user_q;
    axis_o_tdata  = '0;
    axis_o_tkeep  = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (idx_q == IdxW'(i)) begin
        axis_o_tdata = data_q[i*ODataW +: ODataW];
        axis_o_tkeep = keep_q[i*AXIS_O_BYTES +: AXIS_O_BYTES];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slice index, final-slice index and holding register
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d  = idx_q;
    fin_d  = fin_q;
    data_d = data_q;
    keep_d = keep_q;
    user_d = user_q;
    last_d = last_q;
    if (in_hs) begin
      data_d = axis_i_tdata;
      keep_d = axis_i_tkeep;
      user_d = axis_i_tuser;
      last_d = axis_i_tlast;
      idx_d  = '0;
      fin_d  = FinFull;
`ifdef AXIS_WIDTH_DOWN_TRIM_EN
      if (axis_i_tlast) begin
        fin_d = IdxW'(last_slice(keep_ext, R, AXIS_O_BYTES));
      end
`endif
    end else if (out_hs && !slice_last) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      idx_q <= '0;
      fin_q <= '0;
    end else begin
      idx_q <= idx_d;
      fin_q <= fin_d;
    end
  end

  // Payload needs no reset: it is only observed while the FSM is busy.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    keep_q <= keep_d;
    user_q <= user_d;
    last_q <= last_d;
  end

endmodule

// File: tb/tb_axis_width_down.sv
module tb_axis_width_down;

`ifdef AXIS_WIDTH_DOWN_TRIM_EN
  localparam bit Trim = 1'b1;
`else
  localparam bit Trim = 1'b0;
`endif

  localparam int NI = 3;

  logic clk = 1'b0;
  logic sresetn;
  always #5 clk = ~clk;

  // Instance 0: 4 -> 1 bytes
  logic        a_i_tready, a_i_tvalid, a_i_tlast;
  logic [3:0]  a_i_tkeep;
  logic [31:0] a_i_tdata;
  logic [0:0]  a_i_tuser;
  logic        a_o_tready, a_o_tvalid, a_o_tlast;
  logic [0:0]  a_o_tkeep;
  logic [7:0]  a_o_tdata;
  logic [0:0]  a_o_tuser;
  // Instance 1: 8 -> 4 bytes
  logic        b_i_tready, b_i_tvalid, b_i_tlast;
  logic [7:0]  b_i_tkeep;
  logic [63:0] b_i_tdata;
  logic [0:0]  b_i_tuser;
  logic        b_o_tready, b_o_tvalid, b_o_tlast;
  logic [3:0]  b_o_tkeep;
  logic [31:0] b_o_tdata;
  logic [0:0]  b_o_tuser;
  // Instance 2: 2 -> 2 bytes
  logic        c_i_tready, c_i_tvalid, c_i_tlast;
  logic [1:0]  c_i_tkeep;
  logic [15:0] c_i_tdata;
  logic [0:0]  c_i_tuser;
  logic        c_o_tready, c_o_tvalid, c_o_tlast;
  logic [1:0]  c_o_tkeep;
  logic [15:0] c_o_tdata;
  logic [0:0]  c_o_tuser;

  axis_width_down #(.AXIS_I_BYTES(4), .AXIS_O_BYTES(1), .AXIS_USER_BITS(1)) u_dut (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(a_i_tready), .axis_i_tvalid(a_i_tvalid), .axis_i_tlast(a_i_tlast),
    .axis_i_tkeep(a_i_tkeep), .axis_i_tdata(a_i_tdata), .axis_i_tuser(a_i_tuser),
    .axis_o_tready(a_o_tready), .axis_o_tvalid(a_o_tvalid), .axis_o_tlast(a_o_tlast),
    .axis_o_tkeep(a_o_tkeep), .axis_o_tdata(a_o_tdata), .axis_o_tuser(a_o_tuser)
  );

  axis_width_down #(.AXIS_I_BYTES(8), .AXIS_O_BYTES(4), .AXIS_USER_BITS(1)) u_dut_r2 (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(b_i_tready), .axis_i_tvalid(b_i_tvalid), .axis_i_tlast(b_i_tlast),
    .axis_i_tkeep(b_i_tkeep), .axis_i_tdata(b_i_tdata), .axis_i_tuser(b_i_tuser),
    .axis_o_tready(b_o_tready), .axis_o_tvalid(b_o_tvalid), .axis_o_tlast(b_o_tlast),
    .axis_o_tkeep(b_o_tkeep), .axis_o_tdata(b_o_tdata), .axis_o_tuser(b_o_tuser)
  );

  axis_width_down #(.AXIS_I_BYTES(2), .AXIS_O_BYTES(2), .AXIS_USER_BITS(1)) u_dut_r1 (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(c_i_tready), .axis_i_tvalid(c_i_tvalid), .axis_i_tlast(c_i_tlast),
    .axis_i_tkeep(c_i_tkeep), .axis_i_tdata(c_i_tdata), .axis_i_tuser(c_i_tuser),
    .axis_o_tready(c_o_tready), .axis_o_tvalid(c_o_tvalid), .axis_o_tlast(c_o_tlast),
    .axis_o_tkeep(c_o_tkeep), .axis_o_tdata(c_o_tdata), .axis_o_tuser(c_o_tuser)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Generic access to the three instances
  // ---------------------------------------------------------------------------
  function automatic int ib_of(input int id);
    case (id)
      0:       return 4;
      1:       return 8;
      default: return 2;
    endcase
  endfunction

  function automatic int ob_of(input int id);
    case (id)
      0:       return 1;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  task automatic drive(input int id, input bit v, input logic [63:0] d, input logic [7:0] k,
                       input bit l, input bit u);
    case (id)
      0: begin
        a_i_tvalid = v; a_i_tdata = d[31:0]; a_i_tkeep = k[3:0]; a_i_tlast = l; a_i_tuser = u;
      end
      1: begin
        b_i_tvalid = v; b_i_tdata = d; b_i_tkeep = k; b_i_tlast = l; b_i_tuser = u;
      end
      default: begin
        c_i_tvalid = v; c_i_tdata = d[15:0]; c_i_tkeep = k[1:0]; c_i_tlast = l; c_i_tuser = u;
      end
    endcase
  endtask

  task automatic drive_ordy(input int id, input bit r);
    case (id)
      0:       a_o_tready = r;
      1:       b_o_tready = r;
      default: c_o_tready = r;
    endcase
  endtask

  function automatic void sample(input int id, output logic iv, output logic ir,
                                 output logic ov, output logic ordy, output logic [31:0] od,
                                 output logic [3:0] okp, output logic ol, output logic ou);
    case (id)
      0: begin
        iv = a_i_tvalid; ir = a_i_tready; ov = a_o_tvalid; ordy = a_o_tready;
        od = {24'h0, a_o_tdata}; okp = {3'b0, a_o_tkeep}; ol = a_o_tlast; ou = a_o_tuser[0];
      end
      1: begin
        iv = b_i_tvalid; ir = b_i_tready; ov = b_o_tvalid; ordy = b_o_tready;
        od = b_o_tdata; okp = b_o_tkeep; ol = b_o_tlast; ou = b_o_tuser[0];
      end
      default: begin
        iv = c_i_tvalid; ir = c_i_tready; ov = c_o_tvalid; ordy = c_o_tready;
        od = {16'h0, c_o_tdata}; okp = {2'b0, c_o_tkeep}; ol = c_o_tlast; ou = c_o_tuser[0];
      end
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: input beat -> list of expected output slices
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } exp_t;

  exp_t        sbq[NI][$];
  logic [63:0] cur_d[NI];
  logic [7:0]  cur_k[NI];
  bit          cur_l[NI];
  bit          cur_u[NI];
  bit          stall_q[NI];
  exp_t        hold_v[NI];
  int          tl_seen[NI];
  bit          sb_en  = 1'b0;
  bit          rnd_en = 1'b0;

  function automatic int n_slices(input logic [7:0] keep, input bit last, input int ib,
                                  input int ob);
    int n;
    n = ib / ob;
    if (Trim && last) begin
      n = 1;
      for (int b = 0; b < ib; b++) begin
        if (keep[b]) n = b / ob + 1;
      end
    end
    return n;
  endfunction

  function automatic void push_beat(input int id);
    int   ib, ob, n;
    exp_t e;
    ib = ib_of(id);
    ob = ob_of(id);
    n  = n_slices(cur_k[id], cur_l[id], ib, ob);
    for (int s = 0; s < n; s++) begin
      e.data = 32'((cur_d[id] >> (8 * ob * s)) & ((64'h1 << (8 * ob)) - 64'h1));
      e.keep = 4'((cur_k[id] >> (ob * s)) & ((8'h1 << ob) - 8'h1));
      e.last = cur_l[id] && (s == n - 1);
      e.user = cur_u[id];
      sbq[id].push_back(e);
    end
  endfunction

  task automatic mon(input int id);
    logic        iv, ir, ov, ordy, ol, ou;
    logic [31:0] od;
    logic [3:0]  okp;
    exp_t        cur, e;
    sample(id, iv, ir, ov, ordy, od, okp, ol, ou);
    cur = '{data: od, keep: okp, last: ol, user: ou};
    if (stall_q[id]) begin
      chk($sformatf("stall_valid_held[%0d]", id), 64'(ov), 64'd1);
      chk($sformatf("stall_stable[%0d]", id), 64'(cur), 64'(hold_v[id]));
    end
    if (ov && ordy) begin
      if (sbq[id].size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_extra_beat[%0d]: got beat %0h, required none", id, cur);
      end else begin
        e = sbq[id].pop_front();
        chk($sformatf("sb_beat[%0d]", id), 64'(cur), 64'(e));
        if (ol) tl_seen[id]++;
      end
    end
    stall_q[id] = ov && !ordy;
    hold_v[id]  = cur;
    if (iv && ir) push_beat(id);
  endtask

  initial forever begin
    @(negedge clk);
    if (sb_en) begin
      for (int id = 0; id < NI; id++) mon(id);
    end
  end

  // Random output backpressure (~50%) while enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_en) begin
      for (int id = 0; id < NI; id++) drive_ordy(id, 1'($urandom));
    end
  end

  task automatic src(input int id, input int npk);
    logic        iv, ir, ov, ordy, ol, ou;
    logic [31:0] od;
    logic [3:0]  okp;
    bit          acc;
    int          guard;
    for (int p = 0; p < npk; p++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
        cur_d[id] = {$urandom, $urandom};
        cur_k[id] = 8'($urandom);
        cur_l[id] = (b == len - 1);
        cur_u[id] = 1'($urandom);
        drive(id, 1'b1, cur_d[id], cur_k[id], cur_l[id], cur_u[id]);
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
          @(negedge clk);
          sample(id, iv, ir, ov, ordy, od, okp, ol, ou);
          acc = iv && ir;
          @(posedge clk);
          #1;
          guard++;
        end
        chk($sformatf("src_accept[%0d]", id), 64'(acc), 64'd1);
        drive(id, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed single-beat vectors on the 4 -> 1 instance
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    bit          last;
    bit          user;
    int          n_plain;
    int          n_trim;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input string tag, input vec_t v);
    int n;
    n = Trim ? v.n_trim : v.n_plain;
    drive_ordy(0, 1'b1);
    drive(0, 1'b1, 64'(v.data), 8'(v.keep), v.last, v.user);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(a_i_tready), 64'd1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({tag, "_valid"}, 64'(a_o_tvalid), 64'd1);
      chk({tag, "_data"}, 64'(a_o_tdata), 64'((v.data >> (8 * k)) & 32'hFF));
      chk({tag, "_keep"}, 64'(a_o_tkeep), 64'(v.keep[k]));
      chk({tag, "_last"}, 64'(a_o_tlast), 64'(v.last && (k == n - 1)));
      chk({tag, "_user"}, 64'(a_o_tuser), 64'(v.user));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk({tag, "_idle"}, 64'(a_o_tvalid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  localparam int NPK0 = 100;
  localparam int NPK  = 60;

  initial begin
    vec_t       rv;
    logic [31:0] wa, wb, w;
    int          drain;

    vecs[0] = '{32'h44332211, 4'hF, 1'b1, 1'b1, 4, 4};
    vecs[1] = '{32'hDDCCBBAA, 4'h3, 1'b1, 1'b0, 4, 2};
    vecs[2] = '{32'h55667788, 4'h0, 1'b1, 1'b1, 4, 1};
    vecs[3] = '{32'h12345678, 4'h1, 1'b0, 1'b0, 4, 4};
    vecs[4] = '{32'h99AABBCC, 4'h5, 1'b1, 1'b1, 4, 3};

    for (int id = 0; id < NI; id++) begin
      drive(id, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
      drive_ordy(id, 1'b0);
    end
    sresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sresetn = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_o_tvalid", 64'(a_o_tvalid), 64'd0);
    chk("reset_i_tready", 64'(a_i_tready), 64'd1);
    chk("reset_o_tvalid_r2", 64'(b_o_tvalid), 64'd0);
    chk("reset_o_tvalid_r1", 64'(c_o_tvalid), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back beats: 8 slices in 8 cycles, input ready only on final slices
    wa = 32'h44332211;
    wb = 32'h88776655;
    drive_ordy(0, 1'b1);
    drive(0, 1'b1, 64'(wa), 8'hF, 1'b1, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 64'(wb), 8'hF, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      w = (k < 4) ? wa : wb;
      chk("b2b_valid", 64'(a_o_tvalid), 64'd1);
      chk("b2b_data", 64'(a_o_tdata), 64'((w >> (8 * (k % 4))) & 32'hFF));
      chk("b2b_i_tready", 64'(a_i_tready), 64'(k % 4 == 3));
      chk("b2b_last", 64'(a_o_tlast), 64'(k % 4 == 3));
      chk("b2b_user", 64'(a_o_tuser), 64'(k < 4));
      @(posedge clk);
      #1;
      if (k == 3) drive(0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("b2b_idle", 64'(a_o_tvalid), 64'd0);
    @(posedge clk);
    #1;

    // Reset after the second slice discards the rest of the beat
    drive(0, 1'b1, 64'hD4C3B2A1, 8'hF, 1'b1, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_slice0", 64'(a_o_tdata), 64'hA1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_slice1", 64'(a_o_tdata), 64'hB2);
    @(posedge clk);
    #1;
    sresetn = 1'b0;
    @(posedge clk);
    #1;
    sresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_slices", 64'(a_o_tvalid), 64'd0);
      @(posedge clk);
      #1;
    end
    rv = '{32'h5A6B7C8D, 4'hF, 1'b1, 1'b1, 4, 4};
    run_vec("rst_next", rv);

    // Random packets under backpressure on all three instances
    for (int id = 0; id < NI; id++) begin
      stall_q[id] = 1'b0;
      tl_seen[id] = 0;
    end
    sb_en  = 1'b1;
    rnd_en = 1'b1;
    fork
      src(0, NPK0);
      src(1, NPK);
      src(2, NPK);
    join
    rnd_en = 1'b0;
    @(posedge clk);
    #2;
    for (int id = 0; id < NI; id++) drive_ordy(id, 1'b1);
    drain = 0;
    while (drain < 400 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0) begin
      @(posedge clk);
      #1;
      drain++;
    end
    repeat (4) @(posedge clk);
    #1;
    for (int id = 0; id < NI; id++) begin
      chk($sformatf("sb_drained[%0d]", id), 64'(sbq[id].size()), 64'd0);
      chk($sformatf("tlast_count[%0d]", id), 64'(tl_seen[id]), 64'((id == 0) ? NPK0 : NPK));
    end
    sb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
